// File: rtl/cix_align_unit_pkg.sv
// Shared sizing and mode encodings for the count/normalise unit.
// Module parameters default from here so all files agree on widths.
package cix_align_unit_pkg;

  localparam int CIX_ORDER = 3;
  localparam int CIX_W     = 2 ** CIX_ORDER;
  localparam int CIX_CW    = CIX_ORDER + 1;

  // {lead, trail} selects which zero bits cix_core counts
  typedef enum logic [1:0] {
    CNT_NONE  = 2'b00,
    CNT_TRAIL = 2'b01,
    CNT_LEAD  = 2'b10,
    CNT_ZEROS = 2'b11
  } cix_mode_e;

endpackage

// File: rtl/cix_align_unit_chk.sv
// Simulation-only consistency checks between the normaliser and the clz counter.
// Instantiated alongside the unit; never part of the synthesised netlist.
module cix_align_unit_chk #(
  parameter int ORDER = 3,
  parameter int W     = 2 ** ORDER
) (
  input logic           clock,
  input logic           reset,
  input logic           out_valid,
  input logic [ORDER:0] clz,
  input logic [ORDER:0] norm_c,
  input logic [W-1:0]   norm
);

  localparam logic [ORDER:0] W_CNT = (ORDER + 1)'(W);

  a_normc_eq_clz: assert property (@(posedge clock) disable iff (reset)
    out_valid |-> (norm_c == clz));

  a_norm_msb: assert property (@(posedge clock) disable iff (reset)
    out_valid |-> (norm[W-1] == (clz != W_CNT)));

endmodule

// File: rtl/cix_align_unit_core.sv
// Mode-selectable zero counter: leading zeros, trailing zeros or total zeros.
// Fed with an inverted word, the total-zeros mode gives a population count.
module cix_core
  import cix_align_unit_pkg::*;
#(
  parameter int ORDER = CIX_ORDER,
  parameter int W     = 2 ** ORDER
) (
  input  logic [W-1:0]   data,
  input  logic           lead,
  input  logic           trail,
  output logic [ORDER:0] cnt
);

  localparam logic [ORDER:0] CNT_ONE = {{ORDER{1'b0}}, 1'b1};

  cix_mode_e      mode_s;
  logic [ORDER:0] cnt_s;
  logic           hit_s;

  assign mode_s = cix_mode_e'({lead, trail});

  // zero counting for the selected direction; hit_s stops a scan at the first one
  always_comb begin
    cnt_s = {(ORDER + 1){1'b0}};
    hit_s = 1'b0;
    case (mode_s)
      CNT_LEAD: begin
        for (int i = W - 1; i >= 0; i--) begin
          if (hit_s || data[i]) begin
            hit_s = 1'b1;
          end else begin
            cnt_s = cnt_s + CNT_ONE;
          end
        end
      end
      CNT_TRAIL: begin
        for (int i = 0; i < W; i++) begin
          if (hit_s || data[i]) begin
            hit_s = 1'b1;
          end else begin
            cnt_s = cnt_s + CNT_ONE;
          end
        end
      end
      CNT_ZEROS: begin
        for (int i = 0; i < W; i++) begin
          if (!data[i]) begin
            cnt_s = cnt_s + CNT_ONE;
          end else begin
            cnt_s = cnt_s;
          end
        end
      end
      default: begin
        cnt_s = {(ORDER + 1){1'b0}};
      end
    endcase
  end

  assign cnt = cnt_s;

endmodule

// File: rtl/cix_align_unit.sv
// Single-cycle bit analysis: clz, ctz, popcount and left-normalisation of a word,
// all computed combinationally and captured into output registers on in_valid.
module cix_align_unit
  import cix_align_unit_pkg::*;
#(
  parameter int ORDER = CIX_ORDER,
  parameter int W     = 2 ** ORDER
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           in_valid,
  input  logic [W-1:0]   in,
  output logic           out_valid,
  output logic [ORDER:0] clz,
  output logic           clz_z,
  output logic [ORDER:0] ctz,
  output logic           ctz_z,
  output logic [ORDER:0] pop,
  output logic           pop_z,
  output logic [W-1:0]   norm,
  output logic [ORDER:0] norm_c
);

  localparam logic [ORDER:0] W_CNT = (ORDER + 1)'(W);

  logic [ORDER:0] clz_s, ctz_s, pop_s, norm_c_s;
  logic           zero_s;
  logic [W-1:0]   stage_s [ORDER:0];
  logic [ORDER-1:0] shift_s;

  logic           out_valid_r;
  logic [ORDER:0] clz_r, ctz_r, pop_r, norm_c_r;
  logic           zero_r;
  logic [W-1:0]   norm_r;

  cix_core #(.ORDER(ORDER), .W(W)) u_clz (
    .data (in),
    .lead (1'b1),
    .trail(1'b0),
    .cnt  (clz_s)
  );

  cix_core #(.ORDER(ORDER), .W(W)) u_ctz (
    .data (in),
    .lead (1'b0),
    .trail(1'b1),
    .cnt  (ctz_s)
  );

  // zeros of the inverted word are the ones of the original
  cix_core #(.ORDER(ORDER), .W(W)) u_pop (
    .data (~in),
    .lead (1'b1),
    .trail(1'b1),
    .cnt  (pop_s)
  );

  assign zero_s         = (in == {W{1'b0}});
  assign stage_s[ORDER] = in;

  // widest stage first, so each later stage only ever sees a smaller remaining gap
  for (genvar k = ORDER - 1; k >= 0; k--) begin : g_norm
    localparam int SH = 2 ** k;
    assign shift_s[k] = (stage_s[k+1][W-1 -: SH] == {SH{1'b0}});
    assign stage_s[k] = shift_s[k] ? (stage_s[k+1] << SH) : stage_s[k+1];
  end

  // an all-zero word takes every shift, which would read as W-1, so force W
  assign norm_c_s = zero_s ? W_CNT : {1'b0, shift_s};

  // result registers: load on in_valid, hold otherwise, cleared by reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      clz_r       <= {(ORDER + 1){1'b0}};
      ctz_r       <= {(ORDER + 1){1'b0}};
      pop_r       <= {(ORDER + 1){1'b0}};
      norm_c_r    <= {(ORDER + 1){1'b0}};
      zero_r      <= 1'b0;
      norm_r      <= {W{1'b0}};
    end else begin
      out_valid_r <= in_valid;
      if (in_valid) begin
        clz_r    <= clz_s;
        ctz_r    <= ctz_s;
        pop_r    <= pop_s;
        norm_c_r <= norm_c_s;
        zero_r   <= zero_s;
        norm_r   <= stage_s[0];
      end
    end
  end

  assign out_valid = out_valid_r;
  assign clz       = clz_r;
  assign clz_z     = zero_r;
  assign ctz       = ctz_r;
  assign ctz_z     = zero_r;
  assign pop       = pop_r;
  assign pop_z     = zero_r;
  assign norm      = norm_r;
  assign norm_c    = norm_c_r;

endmodule

// File: tb/tb_cix_align_unit.sv
// Scoreboard bench for cix_align_unit (ORDER=3): directed words with hand results,
// a full 0x00..0xFF sweep against a behavioural model, gaps and mid-stream reset.
module tb_cix_align_unit;

  typedef struct packed {
    logic       ov;
    logic [7:0] in_v;
    logic [3:0] clz;
    logic [3:0] ctz;
    logic [3:0] pop;
    logic [2:0] zf;
    logic [7:0] norm;
    logic [3:0] nc;
  } exp_t;

  logic       clock, reset, in_valid;
  logic [7:0] in;
  logic       out_valid, clz_z, ctz_z, pop_z;
  logic [3:0] clz, ctz, pop, norm_c;
  logic [7:0] norm;

  exp_t exp_q[$];
  exp_t dir_tab[8];
  exp_t last_e;
  exp_t zero_e;
  int   n_vec = 0;
  int   n_bad = 0;
  logic end_req = 1'b0;

  cix_align_unit dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in(in),
    .out_valid(out_valid), .clz(clz), .clz_z(clz_z), .ctz(ctz), .ctz_z(ctz_z),
    .pop(pop), .pop_z(pop_z), .norm(norm), .norm_c(norm_c)
  );

  cix_align_unit_chk #(.ORDER(3)) u_chk (
    .clock(clock), .reset(reset), .out_valid(out_valid),
    .clz(clz), .norm_c(norm_c), .norm(norm)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic exp_t model(input logic [7:0] v);
    exp_t m;
    int hi = -1;
    int lo = -1;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        hi = i;
        if (lo < 0) lo = i;
      end
    end
    m.ov   = 1'b1;
    m.in_v = v;
    m.clz  = (hi < 0) ? 4'd8 : 4'(7 - hi);
    m.ctz  = (lo < 0) ? 4'd8 : 4'(lo);
    m.pop  = 4'($countones(v));
    m.zf   = (v == 8'h00) ? 3'b111 : 3'b000;
    m.norm = v << m.clz;
    m.nc   = m.clz;
    return m;
  endfunction

  function automatic exp_t sample();
    exp_t g;
    g.ov   = out_valid;
    g.in_v = 8'h00;
    g.clz  = clz;
    g.ctz  = ctz;
    g.pop  = pop;
    g.zf   = {clz_z, ctz_z, pop_z};
    g.norm = norm;
    g.nc   = norm_c;
    return g;
  endfunction

  task automatic send_exp(input exp_t e);
    @(negedge clock);
    in       = e.in_v;
    in_valid = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic send_model(input logic [7:0] v);
    send_exp(model(v));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      in_valid = 1'b0;
      in       = 8'($urandom_range(0, 255));
    end
  endtask

  // Monitor: reset checks, scoreboard pops on out_valid, hold checks in gaps
  always @(negedge clock) begin
    exp_t g, e;
    string tag;
    g = sample();
    if (reset) begin
      e = zero_e;
      tag = "reset";
      exp_q.delete();
      last_e = zero_e;
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        e = zero_e;
        tag = "spurious_valid";
      end else begin
        e = exp_q.pop_front();
        tag = "result";
        last_e = e;
      end
    end else begin
      e = last_e;
      e.ov = 1'b0;
      tag = "hold";
    end
    g.in_v = e.in_v;
    n_vec++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s in=%h got ov=%b clz=%0d ctz=%0d pop=%0d z=%b norm=%h nc=%0d exp ov=%b clz=%0d ctz=%0d pop=%0d z=%b norm=%h nc=%0d",
               tag, e.in_v, g.ov, g.clz, g.ctz, g.pop, g.zf, g.norm, g.nc,
               e.ov, e.clz, e.ctz, e.pop, e.zf, e.norm, e.nc);
    end
    if (end_req) begin
      n_vec++;
      if (exp_q.size() != 0) begin
        n_bad++;
        $display("FAIL drain got %0d pending results, exp 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout, exp end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    zero_e  = '0;
    last_e  = '0;
    dir_tab[0] = '{ov:1'b1, in_v:8'h00, clz:4'd8, ctz:4'd8, pop:4'd0, zf:3'b111, norm:8'h00, nc:4'd8};
    dir_tab[1] = '{ov:1'b1, in_v:8'h01, clz:4'd7, ctz:4'd0, pop:4'd1, zf:3'b000, norm:8'h80, nc:4'd7};
    dir_tab[2] = '{ov:1'b1, in_v:8'h80, clz:4'd0, ctz:4'd7, pop:4'd1, zf:3'b000, norm:8'h80, nc:4'd0};
    dir_tab[3] = '{ov:1'b1, in_v:8'h2C, clz:4'd2, ctz:4'd2, pop:4'd3, zf:3'b000, norm:8'hB0, nc:4'd2};
    dir_tab[4] = '{ov:1'b1, in_v:8'hFF, clz:4'd0, ctz:4'd0, pop:4'd8, zf:3'b000, norm:8'hFF, nc:4'd0};
    dir_tab[5] = '{ov:1'b1, in_v:8'h10, clz:4'd3, ctz:4'd4, pop:4'd1, zf:3'b000, norm:8'h80, nc:4'd3};
    dir_tab[6] = '{ov:1'b1, in_v:8'h06, clz:4'd5, ctz:4'd1, pop:4'd2, zf:3'b000, norm:8'hC0, nc:4'd5};
    dir_tab[7] = '{ov:1'b1, in_v:8'h55, clz:4'd1, ctz:4'd0, pop:4'd4, zf:3'b000, norm:8'hAA, nc:4'd1};

    reset    = 1'b1;
    in_valid = 1'b1;
    in       = 8'hFF;
    repeat (3) @(negedge clock);
    #2;
    reset    = 1'b0;
    in_valid = 1'b0;
    idle(2);

    for (int i = 0; i < 8; i++) begin
      send_exp(dir_tab[i]);
      if (i == 2 || i == 5) idle(2);
    end
    idle(3);

    for (int i = 0; i < 256; i++) send_model(8'(i));
    idle(2);

    // reset between edges while results are in flight, with in_valid held high
    send_model(8'h5A);
    send_model(8'hA5);
    @(posedge clock);
    #3;
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    #2;
    reset    = 1'b0;
    in_valid = 1'b0;
    idle(2);
    send_exp(dir_tab[3]);
    idle(3);
    end_req = 1'b1;
  end

endmodule

// File: doc/cix_align_unit.md
CIX_ALIGN_UNIT -- requirements
Module: cix_align_unit

Interface
REQ-001 Parameter ORDER, default 3, log2 of the data word width.
REQ-002 Parameter W, default 2**ORDER, data word width; SHALL always equal 2**ORDER.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  qualifies in for capture.
REQ-006 in  input  W  data word under analysis.
REQ-007 out_valid  output  1  results valid, one cycle after an accepted in_valid.
REQ-008 clz  output  ORDER+1  count of leading (MSB-side) zero bits.
REQ-009 clz_z  output  1  captured word was all zeros.
REQ-010 ctz  output  ORDER+1  count of trailing (LSB-side) zero bits.
REQ-011 ctz_z  output  1  captured word was all zeros.
REQ-012 pop  output  ORDER+1  count of one bits.
REQ-013 pop_z  output  1  captured word was all zeros.
REQ-014 norm  output  W  word shifted left until bit W-1 is set.
REQ-015 norm_c  output  ORDER+1  shift distance applied to produce norm.

Function
REQ-016 On each rising clock edge with in_valid=1, all result outputs SHALL be loaded from in; latency is exactly 1 cycle.
REQ-017 out_valid SHALL equal in_valid delayed by one cycle; there is no backpressure.
REQ-018 With in_valid=0, result outputs SHALL hold their previous values.
REQ-019 clz SHALL be the number of zero bits above the highest set bit; clz=W when in=0.
REQ-020 ctz SHALL be the number of zero bits below the lowest set bit; ctz=W when in=0.
REQ-021 pop SHALL be the number of set bits, from 0 to W inclusive.
REQ-022 clz_z, ctz_z and pop_z SHALL each be 1 exactly when in=0.
REQ-023 norm_c SHALL equal clz, and norm SHALL equal in shifted left by norm_c with zero fill (logical shift).
REQ-024 For in=0, norm SHALL be 0 and norm_c SHALL be W.
REQ-025 Counts SHALL be ORDER+1 bits wide so that the value W is representable without wrap.
REQ-026 All counting and normalising logic SHALL be combinational between the input and the output registers, with no multicycle paths.

Reset
REQ-027 While reset=1, out_valid, clz, ctz, pop, norm and norm_c SHALL be 0, and clz_z, ctz_z and pop_z SHALL be 0, independent of clock.
REQ-028 An in_valid that coincides with reset assertion SHALL be discarded.
REQ-029 After reset is deasserted, the first accepted word SHALL produce out_valid on the following edge.

Structure
REQ-030 ORDER, W and the count-width expression ORDER+1 SHALL live in a shared package.
REQ-031 Sub-module cix_core SHALL implement a mode-selectable counter with inputs lead and trail: lead=1,trail=0 gives clz; lead=0,trail=1 gives ctz; lead=1,trail=1 counts zero bits.
REQ-032 cix_core SHALL be instantiated three times; the popcount instance SHALL be fed ~in.
REQ-033 The normaliser SHALL be a log2 shifter of ORDER stages, where stage k shifts by 2**k when the top 2**k bits are zero and contributes bit k of norm_c.
REQ-034 norm_c SHALL be cross-checked against the clz result in simulation.

Verification (ORDER=3)
REQ-035 in=0x00 -> clz=8, ctz=8, pop=0, all zero flags=1, norm=0x00, norm_c=8.
REQ-036 in=0x01 -> clz=7, ctz=0, pop=1, zero flags=0, norm=0x80, norm_c=7; and in=0x80 -> clz=0, ctz=7, pop=1, norm=0x80, norm_c=0.
REQ-037 in=0x2C -> clz=2, ctz=2, pop=3, norm=0xB0, norm_c=2; and in=0xFF -> clz=0, ctz=0, pop=8, norm=0xFF.
REQ-038 Free-running counter 0x00..0xFF with in_valid=1 every cycle -> every output matches a behavioural model one cycle later, and out_valid is continuously 1.
REQ-039 Assert reset mid-stream, off clock edge -> outputs are 0 immediately; in_valid gaps -> outputs hold and out_valid=0.
